probe_buffer_fifo: RTL and testbench

- Synthesizable, parametrised successor to the single-channel simulation probe sink.
- Collects fire-and-forget probe writes, each with a taint shadow word, from CH independent channels.
- Arbitrates the channels round-robin into one DEPTH-entry FIFO, which a downstream logger/DMA drains over a valid/ready port.
- Keeps saturating drop and taint statistics, so fuzzing harnesses can run on FPGA or emulation without DPI.

---
 rtl/probe_buffer_fifo.sv | 250 +++++++++++++++++++++++++
 tb/tb_probe_buffer_fifo.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/probe_buffer_fifo.sv
`default_nettype none
// ============================================================================
// Module   : probe_buffer_fifo
// Purpose  : Collects fire-and-forget probe writes (data + taint shadow) from
//            CH channels, arbitrates them round-robin into one DEPTH-entry
//            FIFO, and presents the FIFO head on a valid/ready port. Keeps
//            saturating counts of lost requests and of tainted entries.
// Ports    : clock       - rising-edge clock
//            reset       - synchronous, active-low reset
//            wen         - per-channel write strobe [CH]
//            write       - per-channel data, channel i at [i*W +: W]
//            write_taint - per-channel taint shadow, same packing
//            out_valid   - FIFO head valid
//            out_ready   - consumer accepts head
//            out_data    - head data
//            out_taint   - head taint shadow
//            out_chan    - source channel of head
//            level       - current occupancy (0..DEPTH)
//            drop_cnt    - saturating count of requests lost
//            taint_sum   - saturating count of accepted tainted entries
//            out_ts      - head timestamp (only with PROBE_BUFFER_TIMESTAMP_EN)
// Options  : define PROBE_BUFFER_TIMESTAMP_EN to add a free-running 32-bit
//            cycle counter stored with each entry and exposed on out_ts.
// Revision : 1.0 - initial release
// ============================================================================
module probe_buffer_fifo #(
  parameter int W     = 64,
  parameter int CH    = 4,
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [CH-1:0]                        wen,
  input  logic [CH*W-1:0]                      write,
  input  logic [CH*W-1:0]                      write_taint,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [W-1:0]                         out_data,
  output logic [W-1:0]                         out_taint,
  output logic [((CH > 1) ? $clog2(CH) : 1)-1:0] out_chan,
  output logic [$clog2(DEPTH):0]               level,
  output logic [CNT_W-1:0]                     drop_cnt,
  output logic [CNT_W-1:0]                     taint_sum
`ifdef PROBE_BUFFER_TIMESTAMP_EN
  ,output logic [31:0]                         out_ts
`endif
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = (CH > 1) ? $clog2(CH) : 1;
  localparam int c_LW = c_AW + 1;

  // Wrap a channel index that is at most 2*CH-2 back into 0..CH-1.
  function automatic int wrap_ch(input int v);
    return (v >= CH) ? (v - CH) : v;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [W-1:0]     r_mem_data  [DEPTH];
  logic [W-1:0]     r_mem_taint [DEPTH];
  logic [c_CW-1:0]  r_mem_chan  [DEPTH];

  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_LW-1:0]  r_level;
  logic [c_CW-1:0]  r_rr_ptr;
  logic [CNT_W-1:0] r_drop_cnt;
  logic [CNT_W-1:0] r_taint_sum;

  logic [W-1:0]     r_head_data;
  logic [W-1:0]     r_head_taint;
  logic [c_CW-1:0]  r_head_chan;

`ifdef PROBE_BUFFER_TIMESTAMP_EN
  logic [31:0]      r_mem_ts [DEPTH];
  logic [31:0]      r_ts;
  logic [31:0]      r_head_ts;
`endif

  // --------------------------------------------------------------------------
  // Round-robin arbitration
  // --------------------------------------------------------------------------
  logic            w_any;
  logic [c_CW-1:0] w_grant;
  logic [W-1:0]    w_sel_data;
  logic [W-1:0]    w_sel_taint;

  always_comb begin
    w_any       = 1'b0;
    w_grant     = '0;
    w_sel_data  = '0;
    w_sel_taint = '0;
    for (int k = 0; k < CH; k++) begin
      if (!w_any && wen[wrap_ch(int'(r_rr_ptr) + k)]) begin
        w_any       = 1'b1;
        w_grant     = c_CW'(wrap_ch(int'(r_rr_ptr) + k));
        w_sel_data  = write[wrap_ch(int'(r_rr_ptr) + k)*W +: W];
        w_sel_taint = write_taint[wrap_ch(int'(r_rr_ptr) + k)*W +: W];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Enqueue / dequeue decisions
  // --------------------------------------------------------------------------
  logic            w_full;
  logic            w_deq;
  logic            w_accept;
  logic [c_AW-1:0] w_rd_ptr_next;
  logic [c_LW-1:0] w_level_next;
  logic [c_CW-1:0] w_rr_next;

  assign out_valid = (r_level != '0);
  assign w_full    = (r_level == c_LW'(DEPTH));
  assign w_deq     = out_valid && out_ready;
  // A full FIFO still accepts when a slot frees up in the same cycle.
  assign w_accept  = w_any && (!w_full || w_deq);

  assign w_rd_ptr_next = w_deq ? (r_rd_ptr + c_AW'(1)) : r_rd_ptr;
  assign w_rr_next     = (w_grant == c_CW'(CH - 1)) ? '0 : (w_grant + c_CW'(1));

  always_comb begin
    w_level_next = r_level;
    case ({w_accept, w_deq})
      2'b10:   w_level_next = r_level + c_LW'(1);
      2'b01:   w_level_next = r_level - c_LW'(1);
      default: w_level_next = r_level;
    endcase
  end

  // --------------------------------------------------------------------------
  // Statistics: drop step = requests this cycle minus the one accepted,
  // added as a single increment and clamped on the widened sum.
  // --------------------------------------------------------------------------
  logic [CNT_W:0]   w_nreq;
  logic [CNT_W:0]   w_drop_sum;
  logic [CNT_W-1:0] w_drop_next;
  logic [CNT_W-1:0] w_taint_next;

  always_comb begin
    w_nreq = '0;
    for (int i = 0; i < CH; i++) begin
      w_nreq = w_nreq + {{CNT_W{1'b0}}, wen[i]};
    end
  end

  assign w_drop_sum  = {1'b0, r_drop_cnt} + w_nreq - {{CNT_W{1'b0}}, w_accept};
  assign w_drop_next = w_drop_sum[CNT_W] ? {CNT_W{1'b1}} : w_drop_sum[CNT_W-1:0];

  assign w_taint_next = (w_accept && (w_sel_taint != '0) && (r_taint_sum != {CNT_W{1'b1}}))
                        ? (r_taint_sum + CNT_W'(1)) : r_taint_sum;

  // --------------------------------------------------------------------------
  // Next head: the entry at the post-edge read pointer. When that slot is the
  // one being written this cycle (empty FIFO, or single entry being drained),
  // forward the incoming write since the memory still holds stale contents.
  // --------------------------------------------------------------------------
  logic            w_fwd;
  logic [W-1:0]    w_head_data;
  logic [W-1:0]    w_head_taint;
  logic [c_CW-1:0] w_head_chan;

  assign w_fwd        = w_accept && (r_wr_ptr == w_rd_ptr_next);
  assign w_head_data  = w_fwd ? w_sel_data  : r_mem_data[w_rd_ptr_next];
  assign w_head_taint = w_fwd ? w_sel_taint : r_mem_taint[w_rd_ptr_next];
  assign w_head_chan  = w_fwd ? w_grant     : r_mem_chan[w_rd_ptr_next];

  // --------------------------------------------------------------------------
  // Storage (no reset needed; validity is tracked by the pointers/level)
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset && w_accept) begin
      r_mem_data[r_wr_ptr]  <= w_sel_data;
      r_mem_taint[r_wr_ptr] <= w_sel_taint;
      r_mem_chan[r_wr_ptr]  <= w_grant;
    end
  end

  // --------------------------------------------------------------------------
  // Control state
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_rr_ptr     <= '0;
      r_drop_cnt   <= '0;
      r_taint_sum  <= '0;
      r_head_data  <= '0;
      r_head_taint <= '0;
      r_head_chan  <= '0;
    end else begin
      r_rd_ptr    <= w_rd_ptr_next;
      r_level     <= w_level_next;
      r_drop_cnt  <= w_drop_next;
      r_taint_sum <= w_taint_next;
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + c_AW'(1);
        r_rr_ptr <= w_rr_next;
      end
      // Hold the last head once empty; it is only meaningful with out_valid.
      if (w_level_next != '0) begin
        r_head_data  <= w_head_data;
        r_head_taint <= w_head_taint;
        r_head_chan  <= w_head_chan;
      end
    end
  end

`ifdef PROBE_BUFFER_TIMESTAMP_EN
  // --------------------------------------------------------------------------
  // Timestamp: free-running cycle counter captured with each accepted entry
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset && w_accept) begin
      r_mem_ts[r_wr_ptr] <= r_ts;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_ts      <= '0;
      r_head_ts <= '0;
    end else begin
      r_ts <= r_ts + 32'd1;
      if (w_level_next != '0) begin
        r_head_ts <= w_fwd ? r_ts : r_mem_ts[w_rd_ptr_next];
      end
    end
  end

  assign out_ts = r_head_ts;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign out_data  = r_head_data;
  assign out_taint = r_head_taint;
  assign out_chan  = r_head_chan;
  assign level     = r_level;
  assign drop_cnt  = r_drop_cnt;
  assign taint_sum = r_taint_sum;

endmodule
`default_nettype wire

// File: tb/tb_probe_buffer_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_probe_buffer_fifo
// Purpose  : Directed self-checking bench for probe_buffer_fifo (W=64, CH=4,
//            DEPTH=16, CNT_W=32). Inputs change 1ns after a rising edge and
//            outputs are sampled at that same point.
// Revision : 1.0 - initial release
// ============================================================================
module tb_probe_buffer_fifo;

  localparam int W     = 64;
  localparam int CH    = 4;
  localparam int DEPTH = 16;
  localparam int CNT_W = 32;

  logic              clock;
  logic              reset;
  logic [CH-1:0]     wen;
  logic [CH*W-1:0]   write;
  logic [CH*W-1:0]   write_taint;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_data;
  logic [W-1:0]      out_taint;
  logic [1:0]        out_chan;
  logic [4:0]        level;
  logic [CNT_W-1:0]  drop_cnt;
  logic [CNT_W-1:0]  taint_sum;
`ifdef PROBE_BUFFER_TIMESTAMP_EN
  logic [31:0]       out_ts;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  probe_buffer_fifo #(.W(W), .CH(CH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .wen         (wen),
    .write       (write),
    .write_taint (write_taint),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_taint   (out_taint),
    .out_chan    (out_chan),
    .level       (level),
    .drop_cnt    (drop_cnt),
    .taint_sum   (taint_sum)
`ifdef PROBE_BUFFER_TIMESTAMP_EN
    ,.out_ts     (out_ts)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [W-1:0] d, input logic [W-1:0] t);
    write[ch*W +: W]       = d;
    write_taint[ch*W +: W] = t;
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    wen         = '0;
    write       = '0;
    write_taint = '0;
    out_ready   = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (5) tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
    n_cmp++; if (level !== 5'd0) begin n_bad++; $display("FAIL reset_level got=%0d want=0", level); end
    n_cmp++; if (drop_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_drop got=%0d want=0", drop_cnt); end
    n_cmp++; if (taint_sum !== 32'd0) begin n_bad++; $display("FAIL reset_taint got=%0d want=0", taint_sum); end
    n_cmp++; if (out_data !== 64'd0 || out_taint !== 64'd0 || out_chan !== 2'd0) begin
      n_bad++; $display("FAIL reset_head got=%h/%h/%0d want=0/0/0", out_data, out_taint, out_chan); end
  endtask

  task automatic test_single();
    do_reset();
    set_ch(2, 64'hDEAD_BEEF, 64'h0);
    wen = 4'b0100;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_no_bypass got=%0b want=0", out_valid); end
    tick();
    wen = '0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid got=%0b want=1", out_valid); end
    n_cmp++; if (out_data !== 64'hDEAD_BEEF) begin n_bad++; $display("FAIL single_data got=%h want=deadbeef", out_data); end
    n_cmp++; if (out_chan !== 2'd2) begin n_bad++; $display("FAIL single_chan got=%0d want=2", out_chan); end
    n_cmp++; if (level !== 5'd1) begin n_bad++; $display("FAIL single_level got=%0d want=1", level); end
    n_cmp++; if (taint_sum !== 32'd0) begin n_bad++; $display("FAIL single_taint got=%0d want=0", taint_sum); end
    tick();
    n_cmp++; if (out_data !== 64'hDEAD_BEEF || level !== 5'd1) begin
      n_bad++; $display("FAIL single_stable got=%h/%0d want=deadbeef/1", out_data, level); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_chan [8];
    exp_chan = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd3, 2'd0, 2'd1};
    do_reset();
    for (int i = 0; i < CH; i++) set_ch(i, 64'(100 + i), 64'h0);
    wen = 4'b1111;
    repeat (4) tick();
    n_cmp++; if (drop_cnt !== 32'd12) begin n_bad++; $display("FAIL rr_drop got=%0d want=12", drop_cnt); end
    n_cmp++; if (level !== 5'd4) begin n_bad++; $display("FAIL rr_level got=%0d want=4", level); end
    // Sparse requests: pointer is back at 0 here.
    wen = 4'b1010; tick();
    wen = 4'b1010; tick();
    wen = 4'b0011; tick();
    wen = 4'b0011; tick();
    wen = '0;
    n_cmp++; if (drop_cnt !== 32'd16) begin n_bad++; $display("FAIL rr_drop2 got=%0d want=16", drop_cnt); end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_chan !== exp_chan[i] || out_data !== 64'(100 + exp_chan[i])) begin
        n_bad++; $display("FAIL rr_order[%0d] got=%0b/%0d/%0d want=1/%0d/%0d", i, out_valid, out_chan, out_data,
                          exp_chan[i], 100 + exp_chan[i]);
      end
      tick();
    end
    out_ready = 1'b0;
    n_cmp++; if (level !== 5'd0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL rr_drained got=%0d/%0b want=0/0", level, out_valid); end
  endtask

  task automatic test_full();
    do_reset();
    wen = 4'b0001;
    for (int i = 0; i < DEPTH; i++) begin
      set_ch(0, 64'(i), 64'h0);
      tick();
    end
    n_cmp++; if (level !== 5'd16 || drop_cnt !== 32'd0) begin
      n_bad++; $display("FAIL full_fill got=%0d/%0d want=16/0", level, drop_cnt); end
    set_ch(0, 64'h77, 64'h0);
    tick();
    n_cmp++; if (level !== 5'd16 || drop_cnt !== 32'd1) begin
      n_bad++; $display("FAIL full_drop got=%0d/%0d want=16/1", level, drop_cnt); end
    set_ch(0, 64'hAA, 64'h0);
    out_ready = 1'b1;
    n_cmp++; if (out_data !== 64'd0) begin n_bad++; $display("FAIL full_head got=%0d want=0", out_data); end
    tick();
    wen = '0;
    n_cmp++; if (level !== 5'd16 || drop_cnt !== 32'd1) begin
      n_bad++; $display("FAIL full_enq_deq got=%0d/%0d want=16/1", level, drop_cnt); end
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++;
      if (out_data !== ((i < 15) ? 64'(i + 1) : 64'hAA)) begin
        n_bad++; $display("FAIL full_drain[%0d] got=%0d want=%0d", i, out_data, (i < 15) ? i + 1 : 170);
      end
      tick();
    end
    out_ready = 1'b0;
    n_cmp++; if (level !== 5'd0) begin n_bad++; $display("FAIL full_empty got=%0d want=0", level); end
  endtask

  task automatic test_taint_and_wrap();
    logic [W-1:0] taints [5];
    taints = '{64'h1, 64'h0, 64'h8000_0000_0000_0000, 64'h0, 64'h1};
    do_reset();
    wen = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      set_ch(1, 64'(10 + i), taints[i]);
      tick();
    end
    wen = '0;
    n_cmp++; if (taint_sum !== 32'd3) begin n_bad++; $display("FAIL taint_sum got=%0d want=3", taint_sum); end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (out_taint !== taints[i] || out_data !== 64'(10 + i)) begin
        n_bad++; $display("FAIL taint_drain[%0d] got=%h/%0d want=%h/%0d", i, out_taint, out_data, taints[i], 10 + i);
      end
      tick();
    end
    // Ready while empty must be harmless.
    tick();
    n_cmp++; if (level !== 5'd0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL taint_empty got=%0d/%0b want=0/0", level, out_valid); end
    // Back-to-back enqueue + dequeue across the pointer wrap.
    out_ready = 1'b0;
    wen = 4'b0001;
    set_ch(0, 64'h1000, 64'h0);
    tick();
    out_ready = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      wen = '0;
      wen[i % CH] = 1'b1;
      set_ch(i % CH, 64'(32'h1000 + i), 64'h0);
      n_cmp++;
      if (out_data !== 64'(32'h1000 + i - 1) || out_chan !== 2'((i - 1) % CH)) begin
        n_bad++; $display("FAIL wrap_head[%0d] got=%h/%0d want=%h/%0d", i, out_data, out_chan, 32'h1000 + i - 1,
                          (i - 1) % CH);
      end
      tick();
      n_cmp++; if (level !== 5'd1) begin n_bad++; $display("FAIL wrap_level[%0d] got=%0d want=1", i, level); end
    end
    wen = '0;
    n_cmp++; if (out_data !== 64'h1014) begin n_bad++; $display("FAIL wrap_last got=%h want=1014", out_data); end
    tick();
    out_ready = 1'b0;
    n_cmp++; if (level !== 5'd0 || taint_sum !== 32'd3) begin
      n_bad++; $display("FAIL wrap_end got=%0d/%0d want=0/3", level, taint_sum); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < CH; i++) set_ch(i, 64'(200 + i), 64'h5);
    wen = 4'b1001;
    repeat (9) tick();
    wen = '0;
    out_ready = 1'b1;
    repeat (2) tick();
    n_cmp++; if (level !== 5'd7 || drop_cnt !== 32'd9 || taint_sum !== 32'd9) begin
      n_bad++; $display("FAIL mid_pre got=%0d/%0d/%0d want=7/9/9", level, drop_cnt, taint_sum); end
    reset = 1'b0;
    wen   = 4'b1111;
    tick();
    reset = 1'b1;
    wen   = '0;
    n_cmp++; if (level !== 5'd0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL mid_level got=%0d/%0b want=0/0", level, out_valid); end
    n_cmp++; if (drop_cnt !== 32'd0 || taint_sum !== 32'd0) begin
      n_bad++; $display("FAIL mid_counters got=%0d/%0d want=0/0", drop_cnt, taint_sum); end
    n_cmp++; if (out_data !== 64'd0 || out_chan !== 2'd0) begin
      n_bad++; $display("FAIL mid_head got=%h/%0d want=0/0", out_data, out_chan); end
    // Round-robin pointer must restart at channel 0.
    out_ready = 1'b0;
    wen = 4'b1111;
    tick();
    wen = '0;
    n_cmp++; if (out_chan !== 2'd0 || out_data !== 64'd200 || drop_cnt !== 32'd3) begin
      n_bad++; $display("FAIL mid_restart got=%0d/%0d/%0d want=0/200/3", out_chan, out_data, drop_cnt); end
  endtask

  initial begin
    reset       = 1'b0;
    wen         = '0;
    write       = '0;
    write_taint = '0;
    out_ready   = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_taint_and_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
